alu_seq_core: RTL
=================

// Module: alu_seq_core
// PURPOSE
//  Registered, multi-cycle successor to the combinational N-bit ALU. Accepts one
//  operation per start pulse and returns registered result, high product half and
//  status flags with a done pulse. Single-cycle ops take 1 clock. MUL uses iterative
//  shift-add and DIV/MOD use restoring division, N cycles each. Sits between operand
//  registers/switch inputs and the display/result register stage.
// PARAMETERS
//  N        4   operand/result width in bits (N >= 2)
//  CNT_W    $clog2(N+1)   iteration counter width (derived, not overridden)
// PORTS
//  clk          in   1   system clock, rising edge
//  rst          in   1   asynchronous, active-high reset
//  start        in   1   request; sampled only when busy==0
//  a            in   N   operand A (unsigned; signed view for overflow only)
//  b            in   N   operand B
//  op           in   4   opcode (see BEHAVIOUR)
//  busy         out  1   high from accepted start until done cycle inclusive
//  done         out  1   one-cycle pulse: outputs valid and updated
//  result       out  N   result / quotient / remainder / product low half
//  result_hi    out  N   product high half for MUL, else 0
//  carry        out  1   ADD carry-out; SUB 1 = no borrow (a>=b); else 0
//  overflow     out  1   signed overflow for ADD/SUB; else 0
//  zero         out  1   result==0 (MUL: full 2N product==0)
//  neg          out  1   result[N-1] (MUL: result_hi[N-1])
//  div_by_zero  out  1   DIV/MOD with b==0
//  illegal_op   out  1   op outside 0000..1001
// BEHAVIOUR
//  - Opcodes: 0000 ADD, 0001 SUB (a-b), 0010 MUL, 0011 DIV (a/b), 0100 MOD (a%b),
//    0101 AND, 0110 OR, 0111 XOR, 1000 SHL (a<<1, 0 in), 1001 SHR (a>>1, 0 in).
//  - a, b, op latched on accepted start; later input changes do not affect the op.
//  - FSM: IDLE -> (start & MUL) MUL_IT; (start & DIV/MOD & b!=0) DIV_IT;
//    (other start) FIN. MUL_IT/DIV_IT run exactly N cycles, then FIN. FIN -> IDLE.
//  - Latency: start at edge t. Single-cycle, illegal and div-by-zero ops assert
//    done at t+1. MUL/DIV/MOD assert done at t+N+1. busy=1 from t+1 through done.
//  - start while busy is ignored (not queued). start on the done cycle is ignored.
//    Next accept is the first cycle with busy==0.
//  - Outputs update only on the done cycle and hold until the next done; done=0
//    otherwise. Flags not defined for an op are 0.
//  - ADD/SUB arithmetic is N+1 bits wide. SUB is a + ~b + 1, carry = bit N.
//    overflow = (a[N-1]==b'[N-1]) & (res[N-1]!=a[N-1]), with b'=b for ADD and ~b for SUB.
//  - MUL: unsigned 2N-bit product {result_hi,result}.
//  - DIV/MOD: unsigned. DIV gives quotient, MOD gives remainder. b==0 gives
//    div_by_zero=1, result={N{1'b1}} for DIV, result=a for MOD, zero/neg evaluated
//    on that value.
//  - Illegal op: result=0, result_hi=0, illegal_op=1, zero=1.
//  - Reset (any time, incl. mid-iteration) clears busy, done, result, result_hi,
//    all flags and the counter. FSM goes to IDLE. No done follows an aborted op.
// TESTING (N=4 unless noted)
//  - ADD a=7,b=9 -> done at t+1, result=0, carry=1, zero=1, overflow=0. ADD 7+1 -> 8, ovf=1.
//  - SUB a=3,b=5 -> result=14, carry=0, neg=1. SUB 5-5 -> result=0, carry=1, zero=1.
//  - MUL a=15,b=15 -> busy 5 cycles, done at t+5, result_hi=14, result=1. Start pulsed
//    at t+2 is ignored, outputs stay at the prior value until done.
//  - DIV 13/4 -> result=3, done t+5. MOD 13%4 -> result=1. DIV 9/0 -> done t+1,
//    result=15, div_by_zero=1. MOD 9%0 -> result=9.
//  - Logic/shift/illegal: AND 12,10 -> 8; XOR 12,10 -> 6; SHR a=9 -> 4; op=1111 ->
//    illegal_op=1, result=0.
//  - Reset asserted at t+2 of a MUL -> busy=0, all outputs 0, no done. Fresh ADD 1+1
//    -> 2. Repeat MUL 255*255 with N=8 -> {hi,lo}=16'hFE01, done at t+9.

Source files
------------

// File: rtl/alu_seq_core.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq_core
//  Description : Registered multi-cycle ALU. ADD/SUB/logic/shift complete in
//                one clock; MUL is iterative shift-add and DIV/MOD restoring
//                division, N iterations each. Results and flags are registered
//                and presented with a one-cycle done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_seq_core #(
    parameter int N     = 4,
    parameter int CNT_W = $clog2(N + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [3:0]   op,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result,
    output logic [N-1:0] result_hi,
    output logic         carry,
    output logic         overflow,
    output logic         zero,
    output logic         neg,
    output logic         div_by_zero,
    output logic         illegal_op
);

    localparam logic [3:0] c_op_add = 4'd0;
    localparam logic [3:0] c_op_sub = 4'd1;
    localparam logic [3:0] c_op_mul = 4'd2;
    localparam logic [3:0] c_op_div = 4'd3;
    localparam logic [3:0] c_op_mod = 4'd4;
    localparam logic [3:0] c_op_and = 4'd5;
    localparam logic [3:0] c_op_or  = 4'd6;
    localparam logic [3:0] c_op_xor = 4'd7;
    localparam logic [3:0] c_op_shl = 4'd8;
    localparam logic [3:0] c_op_shr = 4'd9;

    localparam logic [CNT_W-1:0] c_last = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_MUL_IT = 2'd1,
        S_DIV_IT = 2'd2,
        S_FIN    = 2'd3
    } state_t;

    state_t           r_state;
    logic             r_busy;
    logic             r_done;
    logic [N-1:0]     r_result;
    logic [N-1:0]     r_result_hi;
    logic             r_carry;
    logic             r_overflow;
    logic             r_zero;
    logic             r_neg;
    logic             r_div_by_zero;
    logic             r_illegal_op;
    logic [N-1:0]     r_a;
    logic [N-1:0]     r_b;
    logic [3:0]       r_op;
    logic [N-1:0]     r_x;      // MUL: product high half; DIV: partial remainder
    logic [N-1:0]     r_y;      // MUL: product low half / multiplier; DIV: quotient
    logic [CNT_W-1:0] r_cnt;

    // Single-cycle datapath, evaluated on the live inputs at the accept edge
    logic         w_sub;
    logic [N-1:0] w_b_eff;
    logic [N:0]   w_sum;
    logic [N-1:0] w_res;
    logic         w_carry;
    logic         w_ovf;
    logic         w_dbz;
    logic         w_ill;

    // Iteration datapath
    logic [N:0]   w_mul_sum;
    logic [N-1:0] w_mul_x_nxt;
    logic [N-1:0] w_mul_y_nxt;
    logic [N:0]   w_div_sh;
    logic         w_div_ge;
    logic [N-1:0] w_div_sub;
    logic [N-1:0] w_div_x_nxt;
    logic [N-1:0] w_div_y_nxt;
    logic [N-1:0] w_div_res;

    // Single-cycle ops plus the div-by-zero and illegal-op short cuts
    always_comb begin
        w_sub   = (op == c_op_sub);
        w_b_eff = w_sub ? ~b : b;
        w_sum   = {1'b0, a} + {1'b0, w_b_eff} + {{N{1'b0}}, w_sub};
        w_res   = '0;
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        w_dbz   = 1'b0;
        w_ill   = 1'b0;
        case (op)
            c_op_add, c_op_sub: begin
                w_res   = w_sum[N-1:0];
                w_carry = w_sum[N];
                w_ovf   = (a[N-1] == w_b_eff[N-1]) & (w_sum[N-1] != a[N-1]);
            end
            c_op_mul: w_res = '0;
            c_op_div: begin
                w_res = '1;
                w_dbz = 1'b1;
            end
            c_op_mod: begin
                w_res = a;
                w_dbz = 1'b1;
            end
            c_op_and: w_res = a & b;
            c_op_or:  w_res = a | b;
            c_op_xor: w_res = a ^ b;
            c_op_shl: w_res = {a[N-2:0], 1'b0};
            c_op_shr: w_res = {1'b0, a[N-1:1]};
            default:  w_ill = 1'b1;
        endcase
    end

    // One shift-add step and one restoring-division step
    always_comb begin
        w_mul_sum   = {1'b0, r_x} + (r_y[0] ? {1'b0, r_a} : {(N+1){1'b0}});
        w_mul_x_nxt = w_mul_sum[N:1];
        w_mul_y_nxt = {w_mul_sum[0], r_y[N-1:1]};
        w_div_sh    = {r_x, r_y[N-1]};
        w_div_ge    = (w_div_sh >= {1'b0, r_b});
        w_div_sub   = w_div_sh[N-1:0] - r_b;
        w_div_x_nxt = w_div_ge ? w_div_sub : w_div_sh[N-1:0];
        w_div_y_nxt = {r_y[N-2:0], w_div_ge};
        w_div_res   = (r_op == c_op_div) ? w_div_y_nxt : w_div_x_nxt;
    end

    // Control FSM with registered outputs; outputs change only when done is set
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_result      <= '0;
            r_result_hi   <= '0;
            r_carry       <= 1'b0;
            r_overflow    <= 1'b0;
            r_zero        <= 1'b0;
            r_neg         <= 1'b0;
            r_div_by_zero <= 1'b0;
            r_illegal_op  <= 1'b0;
            r_a           <= '0;
            r_b           <= '0;
            r_op          <= '0;
            r_x           <= '0;
            r_y           <= '0;
            r_cnt         <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_busy <= 1'b1;
                        r_a    <= a;
                        r_b    <= b;
                        r_op   <= op;
                        r_cnt  <= '0;
                        r_x    <= '0;
                        if (op == c_op_mul) begin
                            r_y     <= b;
                            r_state <= S_MUL_IT;
                        end else if ((op == c_op_div || op == c_op_mod) && b != '0) begin
                            r_y     <= a;
                            r_state <= S_DIV_IT;
                        end else begin
                            r_result      <= w_res;
                            r_result_hi   <= '0;
                            r_carry       <= w_carry;
                            r_overflow    <= w_ovf;
                            r_zero        <= (w_res == '0);
                            r_neg         <= w_res[N-1];
                            r_div_by_zero <= w_dbz;
                            r_illegal_op  <= w_ill;
                            r_done        <= 1'b1;
                            r_state       <= S_FIN;
                        end
                    end
                end
                S_MUL_IT: begin
                    r_x   <= w_mul_x_nxt;
                    r_y   <= w_mul_y_nxt;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == c_last) begin
                        r_result      <= w_mul_y_nxt;
                        r_result_hi   <= w_mul_x_nxt;
                        r_carry       <= 1'b0;
                        r_overflow    <= 1'b0;
                        r_zero        <= ({w_mul_x_nxt, w_mul_y_nxt} == '0);
                        r_neg         <= w_mul_x_nxt[N-1];
                        r_div_by_zero <= 1'b0;
                        r_illegal_op  <= 1'b0;
                        r_done        <= 1'b1;
                        r_state       <= S_FIN;
                    end
                end
                S_DIV_IT: begin
                    r_x   <= w_div_x_nxt;
                    r_y   <= w_div_y_nxt;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == c_last) begin
                        r_result      <= w_div_res;
                        r_result_hi   <= '0;
                        r_carry       <= 1'b0;
                        r_overflow    <= 1'b0;
                        r_zero        <= (w_div_res == '0);
                        r_neg         <= w_div_res[N-1];
                        r_div_by_zero <= 1'b0;
                        r_illegal_op  <= 1'b0;
                        r_done        <= 1'b1;
                        r_state       <= S_FIN;
                    end
                end
                S_FIN: begin
                    // start is ignored here: busy is still high on the done cycle
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign result      = r_result;
    assign result_hi   = r_result_hi;
    assign carry       = r_carry;
    assign overflow    = r_overflow;
    assign zero        = r_zero;
    assign neg         = r_neg;
    assign div_by_zero = r_div_by_zero;
    assign illegal_op  = r_illegal_op;

endmodule
`default_nettype wire
